fifo_stream_reader: RTL and testbench

//  Drain stage on the read side of the sync FIFO. Issues rd_en to the FIFO and absorbs its
//  1-cycle read latency in a 3-entry skid buffer. Presents data as a valid/ready stream with
//  m_last framing every PKT_LEN beats. Sits between the FIFO and downstream consumers.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/skid_buf3.sv | 49 ++++
 rtl/fifo_stream_reader.sv | 73 +++++++
 tb/tb_fifo_stream_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side drain stage.
package fifo_pkg;

  localparam int unsigned DWIDTH_DEF  = 16;
  localparam int unsigned PKT_LEN_DEF = 4;
  localparam int unsigned SKID_DEPTH  = 3;

  // Beat counter width: enough to hold PKT_LEN-1, never narrower than one bit.
  function automatic int unsigned beat_cnt_w(input int unsigned pkt_len);
    return (pkt_len <= 1) ? 1 : $clog2(pkt_len);
  endfunction

  function automatic logic [1:0] skid_ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(SKID_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/skid_buf3.sv
// Three-entry circular skid buffer absorbing the FIFO's one-cycle read latency.
module skid_buf3
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic [1:0]        occ
);

  logic [DWIDTH-1:0] r_mem [SKID_DEPTH];
  logic [1:0]        r_head;
  logic [1:0]        r_tail;
  logic [1:0]        r_occ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= din;
        r_tail        <= skid_ptr_inc(r_tail);
      end
      if (pop) begin
        r_head <= skid_ptr_inc(r_head);
      end
      // Simultaneous push and pop leave occupancy unchanged.
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign dout = r_mem[r_head];
  assign occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO drain stage: pops the FIFO into a skid buffer and presents a framed valid/ready stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH  = DWIDTH_DEF,
  parameter int unsigned PKT_LEN = PKT_LEN_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic [15:0]       pkt_cnt
);

  localparam int unsigned   BW        = beat_cnt_w(PKT_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic              r_inflight;
  logic [BW-1:0]     r_beat_cnt;
  logic [15:0]       r_pkt_cnt;
  logic [1:0]        w_occ;
  logic [DWIDTH-1:0] w_skid_dout;
  logic              w_rd_en;
  logic              w_valid;
  logic              w_pop;
  logic              w_last;

  // Reserve a slot for every word already requested so the buffer can never overflow.
  assign w_rd_en = !fifo_empty && (({1'b0, w_occ} + {2'b00, r_inflight}) < 3'(SKID_DEPTH));
  assign w_valid = (w_occ != 2'd0);
  assign w_pop   = w_valid && m_ready;
  assign w_last  = w_valid && (r_beat_cnt == LAST_BEAT);

  skid_buf3 #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk  (clk),
    .rstn (rstn),
    .push (r_inflight),
    .din  (fifo_dout),
    .pop  (w_pop),
    .dout (w_skid_dout),
    .occ  (w_occ)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= 1'b0;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) begin
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
        if (w_last) begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = w_valid;
  assign m_data     = w_skid_dout;
  assign m_last     = w_last;
  assign pkt_cnt    = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO and a stream scoreboard.
module tb_fifo_stream_reader;

  localparam int DW  = 16;
  localparam int PKT = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   pkt_cnt;

  fifo_stream_reader #(
    .DWIDTH (DW),
    .PKT_LEN(PKT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          s_rd, s_valid, s_last;
  logic [DW-1:0] s_data;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            exp_beat = 0;
  int            hs_total = 0;
  int            rd_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample/score at negedge, then advance the FIFO model just after posedge.
  task automatic tick();
    logic [DW-1:0] e;
    logic          e_last;
    @(negedge clk);
    s_rd    = fifo_rd_en;
    s_valid = m_valid;
    s_last  = m_last;
    s_data  = m_data;
    if (s_rd) rd_pulses++;
    if (fifo_empty) check("rd_en_while_empty", {31'd0, s_rd}, 32'd0);
    if (!s_valid) check("last_without_valid", {31'd0, s_last}, 32'd0);
    if (prev_stall) begin
      check("stall_valid", {31'd0, s_valid}, 32'd1);
      check("stall_data", {16'd0, s_data}, {16'd0, prev_data});
      check("stall_last", {31'd0, s_last}, {31'd0, prev_last});
    end
    if (s_valid && m_ready) begin
      check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e      = exp_q.pop_front();
        e_last = (exp_beat == PKT - 1);
        check("beat_data", {16'd0, s_data}, {16'd0, e});
        check("beat_last", {31'd0, s_last}, {31'd0, e_last});
        exp_beat = e_last ? 0 : exp_beat + 1;
        hs_total++;
      end
    end
    prev_stall = s_valid && !m_ready;
    prev_data  = s_data;
    prev_last  = s_last;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() != 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rstn = 1'b0;
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    prev_stall = 1'b0;
    exp_beat   = 0;
    hs_total   = 0;
    #1;
    check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_data"}, {16'd0, m_data}, 32'd0);
    check({tag, "_last"}, {31'd0, m_last}, 32'd0);
    check({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    m_ready    = 1'b0;
    #1;

    // 1: reset and idle
    do_reset("rst");
    repeat (10) tick();
    check("idle_valid", {31'd0, m_valid}, 32'd0);

    // 2: eight words at full rate
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    tick();
    check("t2_first_rd_en", {31'd0, s_rd}, 32'd1);
    check("t2_startup0", {31'd0, s_valid}, 32'd0);
    tick();
    check("t2_startup1", {31'd0, s_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_valid", {31'd0, s_valid}, 32'd1);
      check("t2_data", {16'd0, s_data}, i + 1);
      check("t2_last", {31'd0, s_last}, {31'd0, (i % 4) == 3});
    end
    check("t2_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
    check("t2_drained", exp_q.size(), 32'd0);

    // 3: backpressure with eight words queued
    m_ready   = 1'b0;
    rd_pulses = 0;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    repeat (10) tick();
    check("t3_rd_pulses", rd_pulses, 32'd3);
    check("t3_occ", {30'd0, dut.w_occ}, 32'd3);
    check("t3_valid", {31'd0, m_valid}, 32'd1);
    check("t3_held_data", {16'd0, m_data}, 32'h0001);
    m_ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) tick();
    check("t3_drained", exp_q.size(), 32'd0);
    tick();
    check("t3_pkt_cnt", {16'd0, pkt_cnt}, 32'd4);

    // 4: random backpressure and refill
    for (int c = 0; c < 400; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0 && fq.size() < 8) push_word(16'($urandom_range(0, 16'hFFFF)));
      tick();
    end
    m_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    check("t4_drained", exp_q.size(), 32'd0);
    tick();
    check("t4_pkt_cnt", {16'd0, pkt_cnt}, 32'(hs_total / PKT));

    // 5: packet split by an empty gap
    do_reset("t5_rst");
    m_ready = 1'b1;
    push_word(16'h0051);
    push_word(16'h0052);
    repeat (6) tick();
    check("t5_gap_valid", {31'd0, m_valid}, 32'd0);
    check("t5_gap_beat_cnt", {30'd0, dut.r_beat_cnt}, 32'd2);
    push_word(16'h0053);
    push_word(16'h0054);
    repeat (6) tick();
    check("t5_drained", exp_q.size(), 32'd0);
    check("t5_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    check("t5_beat_cnt", {30'd0, dut.r_beat_cnt}, 32'd0);

    // 6: reset with buffered and inflight data
    m_ready = 1'b0;
    push_word(16'h0101);
    push_word(16'h0102);
    push_word(16'h0103);
    repeat (3) tick();
    check("t6_pre_occ", {30'd0, dut.w_occ}, 32'd2);
    check("t6_pre_inflight", {31'd0, dut.r_inflight}, 32'd1);
    do_reset("t6_rst");
    check("t6_post_occ", {30'd0, dut.w_occ}, 32'd0);
    check("t6_post_inflight", {31'd0, dut.r_inflight}, 32'd0);
    m_ready = 1'b1;
    push_word(16'h00AA);
    for (int c = 0; c < 10 && hs_total == 0; c++) tick();
    check("t6_fresh_beats", hs_total, 32'd1);
    repeat (3) tick();
    check("t6_no_stale", hs_total, 32'd1);
    check("t6_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    check("t6_beat_cnt", {30'd0, dut.r_beat_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
